// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, squash, freeze and halt sequencing for the 5-stage core
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_halt,
  input  logic [2:0]       idex_dst,
  input  logic [2:0]       exmem_dst,
  input  logic [2:0]       memwb_dst,
  input  logic             idex_wen,
  input  logic             exmem_wen,
  input  logic             memwb_wen,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    A_HALTED   = 3'd0,
    A_FREEZE   = 3'd1,
    A_REDIRECT = 3'd2,
    A_STALL    = 3'd3,
    A_DRAIN    = 3'd4,
    A_NORMAL   = 3'd5
  } action_t;

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  action_t          action;
  logic             raw;

  // No forwarding or bypass exists, so any in-flight writer of the register blocks decode (R0 included)
  function automatic logic hit(input logic [2:0] r);
    return (idex_wen  && (idex_dst  == r)) ||
           (exmem_wen && (exmem_dst == r)) ||
           (memwb_wen && (memwb_dst == r));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // RAW detection against all three in-flight destinations
  always_comb begin
    raw = (id_rs_used && hit(id_rs)) || (id_rt_used && hit(id_rt));
  end

  // Priority-ordered selection of this cycle's pipeline action
  always_comb begin
    action = A_NORMAL;
    if (state_q == S_HALTED)               action = A_HALTED;
    else if (mem_busy)                     action = A_FREEZE;
    else if (ex_redirect)                  action = A_REDIRECT;
    else if (raw && (state_q == S_RUN))    action = A_STALL;
    else if (state_q == S_DRAIN)           action = A_DRAIN;
  end

  // Enable/flush decode; reset forces every register to load its flushed value
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (action)
        A_HALTED, A_FREEZE: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        A_REDIRECT: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        A_STALL: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        A_DRAIN: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and saturating statistics; a halt reaching WB outranks a younger redirect
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (wb_halt && !mem_busy)                state_d = S_HALTED;
        else if (id_halt && action == A_NORMAL)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wb_halt && !mem_busy)                state_d = S_HALTED;
        else if (action == A_REDIRECT)           state_d = S_RUN;
      end
      default: state_d = S_HALTED;
    endcase
    halted_d     = (state_d == S_HALTED);
    stall_cnt_d  = sat_inc(stall_cnt_q,  action == A_STALL);
    flush_cnt_d  = sat_inc(flush_cnt_q,  action == A_REDIRECT);
    freeze_cnt_d = sat_inc(freeze_cnt_q, action == A_FREEZE);
  end

  // State and statistics registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      halted_q     <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign halted     = halted_q && !rst;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, idex_dst, exmem_dst, memwb_dst;
  logic        id_rs_used, id_rt_used, id_halt;
  logic        idex_wen, exmem_wen, memwb_wen;
  logic        ex_redirect, mem_busy, wb_halt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush, s_idex_flush, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int tests = 0;
  int fails = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  localparam logic [6:0] O_RST    = 7'b1111111;
  localparam logic [6:0] O_NORMAL = 7'b1111100;
  localparam logic [6:0] O_STALL  = 7'b0011101;
  localparam logic [6:0] O_OFF    = 7'b0000000;
  localparam logic [6:0] O_REDIR  = 7'b1111111;
  localparam logic [6:0] O_DRAIN  = 7'b0111110;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_halt(id_halt),
    .idex_dst(idex_dst), .exmem_dst(exmem_dst), .memwb_dst(memwb_dst),
    .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_halt(id_halt),
    .idex_dst(idex_dst), .exmem_dst(exmem_dst), .memwb_dst(memwb_dst),
    .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_halt = 1'b0;
    idex_dst = 3'd0; exmem_dst = 3'd0; memwb_dst = 3'd0;
    idex_wen = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0;
    ex_redirect = 1'b0; mem_busy = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    chk_outs("rst_outs", O_RST);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("reset_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk_outs("reset_normal", O_NORMAL);

    // RAW on rs: producer walks ID/EX -> EX/MEM -> MEM/WB, 3 stall cycles
    id_rs = 3'd3; id_rs_used = 1'b1; idex_dst = 3'd3; idex_wen = 1'b1;
    #1 chk_outs("raw_idex", O_STALL);
    tick();
    idex_wen = 1'b0; exmem_dst = 3'd3; exmem_wen = 1'b1;
    #1 chk_outs("raw_exmem", O_STALL);
    tick();
    exmem_wen = 1'b0; memwb_dst = 3'd3; memwb_wen = 1'b1;
    #1 chk_outs("raw_memwb", O_STALL);
    tick();
    memwb_wen = 1'b0;
    #1 chk_outs("raw_done", O_NORMAL);
    chk("raw_stall_cnt", {16'd0, stall_cnt}, 32'd3);

    // Unused source does not stall; R0 is an ordinary register
    id_rs_used = 1'b0; idex_wen = 1'b1; idex_dst = 3'd3;
    #1 chk_outs("unused_src_no_stall", O_NORMAL);
    clear_inputs();
    id_rt = 3'd0; id_rt_used = 1'b1; memwb_dst = 3'd0; memwb_wen = 1'b1;
    #1 chk_outs("r0_rt_stall", O_STALL);
    memwb_dst = 3'd5;
    #1 chk_outs("rt_other_dst", O_NORMAL);
    clear_inputs();

    // Redirect under busy: freeze 4 cycles, then one flush cycle
    ex_redirect = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_outs($sformatf("freeze_%0d", i), O_OFF);
      tick();
    end
    mem_busy = 1'b0;
    #1 chk_outs("redirect_after_busy", O_REDIR);
    tick();
    ex_redirect = 1'b0;
    #1 chk_outs("after_redirect", O_NORMAL);
    chk("freeze_cnt_4", {16'd0, freeze_cnt}, 32'd4);
    chk("flush_cnt_1", {16'd0, flush_cnt}, 32'd1);
    chk("stall_cnt_kept", {16'd0, stall_cnt}, 32'd3);

    // Halt: drain, stall ignored in DRAIN, busy delays HALTED
    id_halt = 1'b1;
    #1 chk_outs("halt_normal", O_NORMAL);
    tick();
    id_halt = 1'b0;
    #1 chk_outs("drain_0", O_DRAIN);
    id_rs = 3'd2; id_rs_used = 1'b1; idex_dst = 3'd2; idex_wen = 1'b1;
    #1 chk_outs("drain_ignores_raw", O_DRAIN);
    tick();
    clear_inputs();
    #1 chk_outs("drain_1", O_DRAIN);
    tick();
    wb_halt = 1'b1; mem_busy = 1'b1;
    #1 chk_outs("drain_busy", O_OFF);
    tick();
    chk("busy_blocks_halt", {31'd0, halted}, 32'd0);
    mem_busy = 1'b0;
    #1 chk_outs("drain_2", O_DRAIN);
    tick();
    wb_halt = 1'b0;
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk_outs("halted_outs", O_OFF);
    ex_redirect = 1'b1;
    #1 chk_outs("halted_ignores_redirect", O_OFF);
    tick();
    ex_redirect = 1'b0;
    chk("halted_holds", {31'd0, halted}, 32'd1);
    chk("halted_flush_cnt_hold", {16'd0, flush_cnt}, 32'd1);
    chk("halted_freeze_cnt", {16'd0, freeze_cnt}, 32'd5);

    // Reset out of HALTED
    rst = 1'b1;
    #1 chk_outs("rst_in_halted", O_RST);
    chk("rst_in_halted_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    #1 chk_outs("run_after_rst", O_NORMAL);
    chk("cnt_clear_after_rst", {16'd0, freeze_cnt}, 32'd0);

    // Squashed halt: DRAIN then redirect returns to RUN
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; ex_redirect = 1'b1;
    #1 chk_outs("squash_redirect", O_REDIR);
    tick();
    ex_redirect = 1'b0;
    #1 chk_outs("squash_back_to_run", O_NORMAL);
    chk("squash_halted", {31'd0, halted}, 32'd0);
    chk("squash_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Halt presented during a stall does not drain
    id_halt = 1'b1; id_rs = 3'd1; id_rs_used = 1'b1; exmem_dst = 3'd1; exmem_wen = 1'b1;
    #1 chk_outs("halt_in_stall", O_STALL);
    tick();
    clear_inputs();
    #1 chk_outs("halt_in_stall_no_drain", O_NORMAL);
    chk("halt_in_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Saturation: 20 stall cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_rs = 3'd4; id_rs_used = 1'b1; idex_dst = 3'd4; idex_wen = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_wide_20", {16'd0, stall_cnt}, 32'd20);
    chk("sat_small_15", {28'd0, s_stall_cnt}, 32'd15);
    tick();
    chk("sat_small_hold", {28'd0, s_stall_cnt}, 32'd15);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It detects RAW hazards by comparing decode-stage source registers against in-flight destinations; the core has no forwarding and no register-file bypass. It also squashes wrong-path instructions on taken branches/jumps, freezes the pipe on data-memory busy, drains and halts on `dump`, and keeps saturating hazard statistics.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset (synchronous, active-high)
- id_rs, id_rt  in  3 each  decode-stage source register numbers
- id_rs_used, id_rt_used  in  1 each  source actually read by the decoded instruction
- id_halt  in  1  decoded instruction is `dump`/halt
- idex_dst, exmem_dst, memwb_dst  in  3 each  destination register held in that pipeline register
- idex_wen, exmem_wen, memwb_wen  in  1 each  RegWriteEN held in that pipeline register
- ex_redirect  in  1  EX resolved a taken branch or any jump this cycle
- mem_busy  in  1  data memory not ready; the MEM stage cannot complete
- wb_halt  in  1  `dump` has reached MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  flush to NOP; top ORs each with rst into the register's rst
- halted  out  1  core stopped
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  statistics

## Operation
- State: RUN, DRAIN, HALTED (2-bit register). Reset → RUN.
- raw = (id_rs_used & hit(id_rs)) | (id_rt_used & hit(id_rt)).
  - hit(r) = (idex_wen & idex_dst==r) | (exmem_wen & exmem_dst==r) | (memwb_wen & memwb_dst==r).
  - R0 is an ordinary register; there is no zero exclusion.
- Per-cycle action, in priority order:
  1. HALTED: all enables 0, flushes 0, halted=1.
  2. FREEZE (mem_busy=1): all enables 0, flushes 0.
  3. REDIRECT (ex_redirect=1): all enables 1, ifid_flush=1, idex_flush=1.
  4. STALL (raw=1, state RUN): pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem_en=memwb_en=1.
  5. DRAIN (state DRAIN): pc_en=0, ifid_en=1 with ifid_flush=1, remaining enables 1.
  6. NORMAL: all enables 1, flushes 0.
- Transitions:
  - RUN→DRAIN: id_halt=1 and action is NORMAL. The halt instruction advances into ID/EX this cycle.
  - DRAIN→RUN: action is REDIRECT. The halt was on the wrong path and is squashed by idex_flush.
  - DRAIN→HALTED: wb_halt=1 and mem_busy=0.
  - RUN→HALTED: wb_halt=1 and mem_busy=0 (defensive).
  - HALTED: held until rst.
- Action rules:
  - id_halt while STALL, FREEZE or REDIRECT does not enter DRAIN; it is re-evaluated when the halt is next presented.
  - STALL has no effect in DRAIN; ID holds only NOPs there.
- Counters, each saturating at all-ones and holding in HALTED:
  - stall_cnt: +1 per STALL cycle.
  - flush_cnt: +1 per REDIRECT cycle.
  - freeze_cnt: +1 per FREEZE cycle.
- While rst=1: all enables 1, both flushes 1, halted=0. Counters and state clear on that edge.

## Timing
- All enable/flush outputs are combinational from the current inputs and state, and take effect at the same posedge.
- State, counters and halted update on posedge clk. halted and the counters are registered; reset value 0.
- A RAW stall lasts until the producer has left MEM/WB:
  - 3 cycles when the producer is in ID/EX.
  - 2 cycles when the producer is in EX/MEM.
  - 1 cycle when the producer is in MEM/WB.
- REDIRECT costs 2 bubbles. The PC loads the target at the same edge that IF/ID and ID/EX are flushed.
- mem_busy at the same time as ex_redirect: FREEZE wins. ex_redirect stays asserted because EX is frozen, so the flush happens in the first cycle after mem_busy falls.
- mem_busy at the same time as wb_halt: no HALTED transition until mem_busy=0.
- rst mid-DRAIN or in HALTED: RUN on the next cycle, counters 0.

## Test plan
- Reset: rst=1 one cycle → state RUN, halted=0, all counters 0. During rst, all enables 1 and both flushes 1.
- RAW: idex_dst=3, idex_wen=1, id_rs=3, id_rs_used=1, producer advancing normally → pc_en=ifid_en=0 and idex_flush=1 for exactly 3 cycles, then NORMAL; stall_cnt=3.
- Redirect + busy: ex_redirect=1 and mem_busy=1 for 4 cycles, then mem_busy=0 → 4 cycles with all enables 0, then one cycle with ifid_flush=idex_flush=1; freeze_cnt=4, flush_cnt=1.
- Halt: id_halt=1 in NORMAL → DRAIN with pc_en=0 and ifid_flush=1; wb_halt=1 three cycles later → halted=1 and all enables 0 until rst.
- Squashed halt: enter DRAIN, then ex_redirect=1 next cycle → state RUN, pc_en=1, halted stays 0.
- Saturation: CNT_W=4, hold raw=1 for 20 cycles → stall_cnt=15 and holds at 15.
